uart_tx_core: RTL and testbench



---
 rtl/uart_tx_core.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// Byte-serial UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Every output is registered; ready paces the upstream packetizer.
module uart_tx_core #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ready,
  output logic       txd,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic parity_of(input logic [7:0] b);
    logic p;
    p = 1'b0;
    if (PARITY == 1) p = ^b;
    else if (PARITY == 2) p = ~(^b);
    return p;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             last_stop;
  logic             load;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign last_stop = (STOP_BITS < 2) ? 1'b1 : stop_idx_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    load       = 1'b0;

    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + CNT_W'(1);

    case (state_q)
      S_IDLE: load = tx_start && ready_q;
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            done_d = 1'b1;
            // A held request chains straight into the next start bit so
            // back-to-back frames run with no idle gap on the line.
            if (tx_start) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              ready_d = 1'b1;
              txd_d   = 1'b1;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        txd_d   = 1'b1;
      end
    endcase

    if (load) begin
      shift_d = tx_data;
      par_d   = parity_of(tx_data);
      state_d = S_START;
      baud_d  = '0;
      txd_d   = 1'b0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign ready   = ready_q;
  assign txd     = txd_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four parity/stop configurations driven in parallel,
// cycle-exact frame profiles from a vector table plus a byte-decoding scoreboard.
module tb_uart_tx_core;

  localparam int CPB = 10;

  logic       CLK = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] rdy_v, txd_v, done_v;

  int nchecks = 0;
  int nerr    = 0;
  bit rx_en   = 1'b0;
  logic [7:0] sb_q[$];

  always #5 CLK = ~CLK;

  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(CLK), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ready(rdy_v[0]), .txd(txd_v[0]), .tx_done(done_v[0]));
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u1 (
    .CLK(CLK), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ready(rdy_v[1]), .txd(txd_v[1]), .tx_done(done_v[1]));
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u2 (
    .CLK(CLK), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ready(rdy_v[2]), .txd(txd_v[2]), .tx_done(done_v[2]));
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(2)) u3 (
    .CLK(CLK), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ready(rdy_v[3]), .txd(txd_v[3]), .tx_done(done_v[3]));

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int flen(input int d);
    return 9 + ((d == 0) ? 0 : 1) + ((d == 3) ? 2 : 1);
  endfunction

  // Line level expected in cycle k after capture for instance d.
  function automatic logic exp_txd(input int d, input logic [7:0] b, input logic pe,
                                   input logic po, input int k);
    int slot;
    slot = (k - 1) / CPB;
    if (k > flen(d) * CPB) return 1'b1;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (d != 0 && slot == 9) return (d == 2) ? po : pe;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic pe, input logic po, input bit push);
    int txd_bad[4];
    int rdy_bad[4];
    int done_bad[4];
    for (int d = 0; d < 4; d++) begin
      txd_bad[d] = 0; rdy_bad[d] = 0; done_bad[d] = 0;
    end
    @(negedge CLK);
    tx_data  = b;
    tx_start = 1'b1;
    if (push) sb_q.push_back(b);
    for (int k = 1; k <= 125; k++) begin
      @(negedge CLK);
      if (k == 1) tx_start = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (txd_v[d] !== exp_txd(d, b, pe, po, k)) txd_bad[d]++;
        if (rdy_v[d] !== (k > flen(d) * CPB)) rdy_bad[d]++;
        if (done_v[d] !== (k == flen(d) * CPB + 1)) done_bad[d]++;
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("txd_profile_u%0d_%02h bad_cycles", d, b), txd_bad[d], 0);
      chk($sformatf("ready_profile_u%0d_%02h bad_cycles", d, b), rdy_bad[d], 0);
      chk($sformatf("done_profile_u%0d_%02h bad_cycles", d, b), done_bad[d], 0);
    end
  endtask

  // Scoreboard receiver on the no-parity, one-stop instance.
  initial begin
    logic [7:0] rxb;
    rxb = 8'h00;
    forever begin
      @(negedge CLK);
      if (rx_en && txd_v[0] === 1'b0) begin
        repeat (15) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          rxb[i] = txd_v[0];
          if (i < 7) repeat (10) @(negedge CLK);
        end
        repeat (10) @(negedge CLK);
        chk("rx_stop_bit", txd_v[0], 1);
        if (sb_q.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL rx_extra_frame: got %02h expected no frame", rxb);
        end else begin
          chk("rx_byte", rxb, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    vec_t tbl[5];
    int   cnt;
    int   gap;

    tbl[0] = '{8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b1, 1'b0};

    reset    = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("reset_txd_%0d", i), txd_v, 4'hF);
      chk($sformatf("reset_ready_%0d", i), rdy_v, 4'hF);
      chk($sformatf("reset_done_%0d", i), done_v, 4'h0);
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    @(negedge CLK);
    chk("post_reset_txd", txd_v, 4'hF);
    chk("post_reset_ready", rdy_v, 4'hF);
    rx_en = 1'b1;
    repeat (3) @(negedge CLK);

    for (int v = 0; v < 5; v++) send_frame(tbl[v].data, tbl[v].par_even, tbl[v].par_odd, 1'b1);

    // Busy rejection: a second request mid-frame must be ignored.
    cnt = 0;
    gap = 0;
    @(negedge CLK);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    sb_q.push_back(8'h00);
    for (int k = 1; k <= 140; k++) begin
      @(negedge CLK);
      if (k == 1) tx_start = 1'b0;
      if (k == 30) begin tx_data = 8'hFF; tx_start = 1'b1; end
      if (k == 31) tx_start = 1'b0;
      if (k >= 11 && k <= 90 && txd_v[0] !== 1'b0) cnt++;
      if (k >= 101 && txd_v[0] !== 1'b1) gap++;
      if (k == 100) chk("busy_ready_100", rdy_v[0], 0);
      if (k == 101) chk("busy_ready_101", rdy_v[0], 1);
    end
    chk("busy_data_zero bad_cycles", cnt, 0);
    chk("busy_no_second_frame bad_cycles", gap, 0);

    // Back-to-back with a held request.
    gap = 0;
    @(negedge CLK);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    sb_q.push_back(8'h55);
    for (int k = 1; k <= 230; k++) begin
      @(negedge CLK);
      if (k == 1) begin tx_data = 8'h0F; sb_q.push_back(8'h0F); end
      if (k == 100) begin
        chk("b2b_stop_txd", txd_v[0], 1);
        chk("b2b_ready_100", rdy_v[0], 0);
      end
      if (k == 101) begin
        chk("b2b_second_start", txd_v[0], 0);
        chk("b2b_ready_101", rdy_v[0], 0);
        chk("b2b_done_101", done_v[0], 1);
        tx_start = 1'b0;
      end
      if (k >= 101 && k <= 110 && txd_v[0] !== 1'b0) gap++;
      if (k == 200) chk("b2b_ready_200", rdy_v[0], 0);
      if (k == 201) begin
        chk("b2b_ready_201", rdy_v[0], 1);
        chk("b2b_done_201", done_v[0], 1);
      end
    end
    chk("b2b_start_bit bad_cycles", gap, 0);

    // Reset abort mid-frame, then a clean frame.
    rx_en = 1'b0;
    cnt   = 0;
    @(negedge CLK);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge CLK);
      if (k == 1) tx_start = 1'b0;
      if (k == 45) reset = 1'b1;
      if (k == 46) begin
        chk("abort_txd", txd_v, 4'hF);
        chk("abort_ready", rdy_v, 4'hF);
        reset = 1'b0;
      end
      if (k >= 46 && done_v !== 4'h0) cnt++;
    end
    chk("abort_no_done cycles", cnt, 0);
    rx_en = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);

    repeat (20) @(negedge CLK);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
